// File: rtl/seven_seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver: latches encoder bytes on a load strobe,
// scans them onto a shared active-low bus with inter-digit blanking and optional blink.
module seven_seg_scan_driver #(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK        = 500,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] seg_dig1_i,
  input  logic [7:0] seg_dig2_i,
  input  logic       load_i,
  input  logic       blink_i,
  output logic [7:0] segments_o,
  output logic [1:0] anodes_o,
  output logic       frame_done_o
);

  localparam int unsigned SLOT_MAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int unsigned CNT_W    = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int unsigned FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_BLANK1 = 2'd0,
    ST_SHOW1  = 2'd1,
    ST_BLANK2 = 2'd2,
    ST_SHOW2  = 2'd3
  } scan_state_e;

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       active1_q, active1_d;
  logic [7:0]       active2_q, active2_d;
  logic [7:0]       pend1_q, pend1_d;
  logic [7:0]       pend2_q, pend2_d;
  logic             pend_valid_q, pend_valid_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [7:0]       segments_q, segments_d;
  logic [1:0]       anodes_q, anodes_d;
  logic             frame_done_q, frame_done_d;

  logic frame_end;
  logic seg_blanked;

  // Last cycle of the frame: the edge closing it is where displayed data may change.
  assign frame_end = (state_q == ST_SHOW2) && (cnt_q == DIV_LAST);

  // Scan sequencer: the slot counter restarts on every state change.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      ST_BLANK1: if (cnt_q == BLANK_LAST) begin
        state_d = ST_SHOW1;
        cnt_d   = '0;
      end
      ST_SHOW1: if (cnt_q == DIV_LAST) begin
        state_d = ST_BLANK2;
        cnt_d   = '0;
      end
      ST_BLANK2: if (cnt_q == BLANK_LAST) begin
        state_d = ST_SHOW2;
        cnt_d   = '0;
      end
      ST_SHOW2: if (cnt_q == DIV_LAST) begin
        state_d = ST_BLANK1;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_BLANK1;
        cnt_d   = '0;
      end
    endcase
  end

  // Display data: loads are staged in the pending pair and promoted only at the
  // frame boundary, so a frame never shows a mix of old and new bytes.
  always_comb begin
    active1_d    = active1_q;
    active2_d    = active2_q;
    pend1_d      = pend1_q;
    pend2_d      = pend2_q;
    pend_valid_d = pend_valid_q;
    if (frame_end) begin
      if (load_i) begin
        active1_d    = seg_dig1_i;
        active2_d    = seg_dig2_i;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        active1_d    = pend1_q;
        active2_d    = pend2_q;
        pend_valid_d = 1'b0;
      end
    end else if (load_i) begin
      pend1_d      = seg_dig1_i;
      pend2_d      = seg_dig2_i;
      pend_valid_d = 1'b1;
    end
  end

  // Blink phase runs continuously; the blink input only gates its effect on segments.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
  end

  // Outputs are decoded from next-state values so the flops line up with the state
  // occupying each cycle, and no combinational glitch reaches the pins.
  assign seg_blanked = blink_i && blink_phase_d;

  always_comb begin
    segments_d   = 8'hFF;
    anodes_d     = 2'b11;
    frame_done_d = (state_d == ST_SHOW2) && (cnt_d == DIV_LAST);
    unique case (state_d)
      ST_SHOW1: begin
        anodes_d = 2'b10;
        if (!seg_blanked) segments_d = ~active1_d;
      end
      ST_SHOW2: begin
        anodes_d = 2'b01;
        if (!seg_blanked) segments_d = ~active2_d;
      end
      default: begin
        segments_d = 8'hFF;
        anodes_d   = 2'b11;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_BLANK1;
      cnt_q         <= '0;
      active1_q     <= 8'h00;
      active2_q     <= 8'h00;
      pend1_q       <= 8'h00;
      pend2_q       <= 8'h00;
      pend_valid_q  <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      segments_q    <= 8'hFF;
      anodes_q      <= 2'b11;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active1_q     <= active1_d;
      active2_q     <= active2_d;
      pend1_q       <= pend1_d;
      pend2_q       <= pend2_d;
      pend_valid_q  <= pend_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      segments_q    <= segments_d;
      anodes_q      <= anodes_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign segments_o   = segments_q;
  assign anodes_o     = anodes_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with DIV=4, BLANK=1, BLINK_FRAMES=2 (10-cycle frame).
module tb_seven_seg_scan_driver;

  logic       clk;
  logic       rst;
  logic [7:0] d1;
  logic [7:0] d2;
  logic       load;
  logic       blink;
  logic [7:0] segs;
  logic [1:0] anodes;
  logic       fd;

  int n_checks;
  int n_errors;
  int cyc;
  logic blink_prev;

  seven_seg_scan_driver #(
    .DIV          (4),
    .BLANK        (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .seg_dig1_i   (d1),
    .seg_dig2_i   (d2),
    .load_i       (load),
    .blink_i      (blink),
    .segments_o   (segs),
    .anodes_o     (anodes),
    .frame_done_o (fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock; blink_prev holds the blink level the edge samples.
  task automatic tick();
    blink_prev = blink;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [1:0] exp_an(input int p);
    if (p == 0 || p == 5) return 2'b11;
    if (p <= 4) return 2'b10;
    return 2'b01;
  endfunction

  task automatic check_reset_outputs();
    check("rst_segments", segs, 8'hFF);
    check("rst_anodes", {6'b0, anodes}, 8'h03);
    check("rst_frame_done", {7'b0, fd}, 8'h00);
  endtask

  // Check the current cycle against hand-chosen active bytes a1/a2, then advance.
  task automatic do_cycle(input logic [7:0] a1, input logic [7:0] a2);
    int p;
    int f;
    logic [7:0] es;
    logic [1:0] ea;
    bit blanked;
    p = cyc % 10;
    f = cyc / 10;
    blanked = blink_prev && (((f / 2) % 2) == 1);
    ea = exp_an(p);
    if (ea == 2'b10)      es = blanked ? 8'hFF : ~a1;
    else if (ea == 2'b01) es = blanked ? 8'hFF : ~a2;
    else                  es = 8'hFF;
    check("anodes", {6'b0, anodes}, {6'b0, ea});
    check("segments", segs, es);
    check("frame_done", {7'b0, fd}, {7'b0, (p == 9)});
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    blink_prev = 1'b0;
    rst   = 1'b1;
    load  = 1'b0;
    blink = 1'b0;
    d1    = 8'h00;
    d2    = 8'h00;

    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outputs();
    end
    rst = 1'b0;
    cyc = 0;

    // Frame 0: load 5B/77 at cycle 2, frame still shows Active=0.
    for (int p = 0; p < 10; p++) begin
      load = (p == 2);
      d1 = 8'h5B; d2 = 8'h77;
      do_cycle(8'h00, 8'h00);
    end
    // Frame 1: shows 5B/77; two loads, the last must win.
    for (int p = 0; p < 10; p++) begin
      load = (p == 3) || (p == 5);
      if (p == 3) begin d1 = 8'h06; d2 = 8'h06; end
      if (p == 5) begin d1 = 8'h4F; d2 = 8'h66; end
      do_cycle(8'h5B, 8'h77);
    end
    // Frame 2: shows 4F/66; load on the frame-end cycle.
    for (int p = 0; p < 10; p++) begin
      load = (p == 9);
      d1 = 8'h3F; d2 = 8'h3F;
      do_cycle(8'h4F, 8'h66);
    end
    // Frame 3: shows 3F/3F; frame-end load of 5B/77.
    for (int p = 0; p < 10; p++) begin
      load = (p == 9);
      d1 = 8'h5B; d2 = 8'h77;
      do_cycle(8'h3F, 8'h3F);
    end
    // Frame 4: pending load at cycle 41, reset at cycle 43 with a coinciding load.
    for (int p = 0; p < 4; p++) begin
      load = (p == 1) || (p == 3);
      if (p == 1) begin d1 = 8'h11; d2 = 8'h22; end
      if (p == 3) begin d1 = 8'hAA; d2 = 8'hBB; rst = 1'b1; end
      do_cycle(8'h5B, 8'h77);
    end
    check_reset_outputs();
    rst  = 1'b0;
    load = 1'b0;
    cyc  = 0;

    // After reset neither the pending bytes nor the reset-cycle load may appear.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 10; p++) begin
        load = (f == 1) && (p == 9);
        d1 = 8'h5B; d2 = 8'h77;
        do_cycle(8'h00, 8'h00);
      end
    end
    load = 1'b0;

    // Blink: frames 2-3 and 6 are the blank phase; blink dropped briefly in frame 3.
    for (int f = 2; f < 7; f++) begin
      for (int p = 0; p < 10; p++) begin
        blink = (f == 3) ? (p < 2) : 1'b1;
        do_cycle(8'h5B, 8'h77);
      end
    end

    // 100 frames of random load/blink: scan pattern and frame strobe must hold.
    for (int i = 0; i < 1000; i++) begin
      int p;
      load  = 1'($urandom_range(0, 1));
      blink = 1'($urandom_range(0, 1));
      d1    = 8'($urandom);
      d2    = 8'($urandom);
      p = cyc % 10;
      check("anodes_not_both_low", {7'b0, (anodes != 2'b00)}, 8'h01);
      check("rand_anodes", {6'b0, anodes}, {6'b0, exp_an(p)});
      check("rand_frame_done", {7'b0, fd}, {7'b0, (p == 9)});
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
